// File: rtl/shift_ring_mem.sv
// Bit-serial ring-buffer memory: one rotating shift-register loop whose low word is the head window.
// Requests rotate the loop forward the minimum distance to the target, then commit one read/modify cycle.
module shift_ring_mem #(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 1,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic                  busy
);

  localparam int WPW   = DATA_WIDTH / SHIFT_WIDTH;
  localparam int TOTAL = DEPTH * DATA_WIDTH;
  localparam int CNT_W = $clog2(DEPTH * WPW + 1);
  localparam int PH_W  = (WPW > 1) ? $clog2(WPW) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      WPW_C     = CNT_W'(WPW);
  localparam logic [CNT_W-1:0]      CLR_STEPS = CNT_W'(DEPTH * WPW);
  localparam logic [PH_W-1:0]       PH_LAST   = PH_W'(WPW - 1);

  if (DATA_WIDTH % SHIFT_WIDTH != 0) begin : g_bad_shift_width
    $error("shift_ring_mem: DATA_WIDTH must be a multiple of SHIFT_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, CLEAR} state_t;

  state_t                state;
  logic [TOTAL-1:0]      ring;
  logic [CNT_W-1:0]      cnt;
  logic [PH_W-1:0]       phase;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic [TOTAL-1:0]      ring_rot;
  logic [TOTAL-1:0]      ring_clr;
  logic [DATA_WIDTH-1:0] head_word;
  logic [ADDR_WIDTH-1:0] head_inc;
  logic [ADDR_WIDTH:0]   diff_word;
  logic [CNT_W-1:0]      steps;
  logic                  addr_ok;

  // The head word sits in the low bits; rotating right moves the next word into the window.
  assign ring_rot  = {ring[SHIFT_WIDTH-1:0], ring[TOTAL-1:SHIFT_WIDTH]};
  assign ring_clr  = {{SHIFT_WIDTH{1'b0}}, ring[TOTAL-1:SHIFT_WIDTH]};
  assign head_word = ring[DATA_WIDTH-1:0];
  assign head_inc  = (head_addr == LAST_ADDR) ? '0 : head_addr + ADDR_WIDTH'(1);
  assign addr_ok   = ({1'b0, req_addr} < DEPTH_X);

  always_comb begin
    diff_word = '0;
    if (req_addr >= head_addr)
      diff_word = {1'b0, req_addr} - {1'b0, head_addr};
    else
      diff_word = {1'b0, req_addr} + DEPTH_X - {1'b0, head_addr};
    steps = CNT_W'(diff_word) * WPW_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ring       <= '0;
      cnt        <= '0;
      phase      <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      head_addr  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            wdata_q   <= req_wdata;
            phase     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            err_q     <= 1'b0;
            if (req_op == 2'b11) begin
              state <= CLEAR;
              cnt   <= CLR_STEPS;
            end else if (!addr_ok) begin
              state      <= COMMIT;
              err_q      <= 1'b1;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (steps == '0) begin
              state      <= COMMIT;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= head_word;
            end else begin
              state <= SHIFT;
              cnt   <= steps;
            end
          end
        end
        SHIFT, CLEAR: begin
          ring <= (state == CLEAR) ? ring_clr : ring_rot;
          cnt  <= cnt - CNT_W'(1);
          // head_addr follows whole-word steps only, so it lands on the target exactly at COMMIT
          if (phase == PH_LAST) begin
            phase     <= '0;
            head_addr <= head_inc;
          end else begin
            phase <= phase + PH_W'(1);
          end
          if (cnt == CNT_W'(1)) begin
            state      <= COMMIT;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= (state == CLEAR) ? '0 : ring_rot[DATA_WIDTH-1:0];
          end
        end
        COMMIT: begin
          if (!err_q) begin
            if (op_q == 2'b01)
              ring[DATA_WIDTH-1:0] <= wdata_q;
            else if (op_q == 2'b10)
              ring[DATA_WIDTH-1:0] <= head_word + DATA_WIDTH'(1);
          end
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ring_mem.sv
// Scoreboard bench for shift_ring_mem (DEPTH=12, SHIFT_WIDTH=4): a word-array model predicts every response,
// and a negedge monitor pops and compares whenever resp_valid is seen.
module tb_shift_ring_mem;

  localparam int DEPTH = 12;
  localparam int DW    = 8;
  localparam int SW    = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int WPW   = DW / SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] head_addr;
  logic          busy;

  shift_ring_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .head_addr(head_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rdata;
    int unsigned err;
    int unsigned head;
    int          latency;
    int          accept_cycle;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            model_head = 0;
  int            compared   = 0;
  int            mismatched = 0;
  int            cycle      = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: every response is matched against the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_err", resp_err, e.err);
        checkOutput("head_addr", head_addr, e.head);
        checkOutput("latency", cycle - e.accept_cycle, e.latency);
        checkOutput("busy_in_commit", busy, 1);
      end
    end
  end

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_head = 0;
    sb.delete();
  endtask

  // Reference behaviour: forward ring distance from head to target, word-granular memory array.
  task automatic modelAccept(input int op, input int addr, input logic [DW-1:0] wdata);
    exp_t e;
    e.accept_cycle = cycle;
    if (op == 3) begin
      e.rdata = 0; e.err = 0; e.head = model_head; e.latency = DEPTH * WPW + 1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (addr >= DEPTH) begin
      e.rdata = 0; e.err = 1; e.head = model_head; e.latency = 1;
    end else begin
      e.latency = ((addr - model_head + DEPTH) % DEPTH) * WPW + 1;
      e.rdata   = model_mem[addr];
      e.err     = 0;
      e.head    = addr;
      model_head = addr;
      if (op == 1) model_mem[addr] = wdata;
      else if (op == 2) model_mem[addr] = model_mem[addr] + 8'd1;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; raises valid at once and holds it until the block is ready.
  task automatic applyStimulus(input int op, input int addr, input logic [DW-1:0] wdata);
    int waitc = 0;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_addr  = AW'(addr);
    req_wdata = wdata;
    while (!req_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      checkOutput("ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    modelAccept(op, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waitc = 0;
    while ((sb.size() != 0 || !req_ready) && waitc < 500) begin
      @(negedge clk);
      waitc++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_head_addr"}, head_addr, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed: read after reset, write/read back, increment wrap, error, clear
    applyStimulus(0, 5, 8'h00);
    applyStimulus(1, 3, 8'hA5);
    applyStimulus(0, 3, 8'h00);
    applyStimulus(1, 7, 8'hFF);
    applyStimulus(2, 7, 8'h00);
    applyStimulus(0, 7, 8'h00);
    applyStimulus(0, 13, 8'h00);
    applyStimulus(0, 7, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1, i, 8'(8'h11 * (i + 1)));
    applyStimulus(3, 9, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, i, 8'h00);
    applyStimulus(0, 11, 8'h00);
    waitDrain();

    // Reset in the middle of a long rotation aborts the write and clears the ring
    target = (model_head + DEPTH - 1) % DEPTH;
    applyStimulus(1, target, 8'h5A);
    repeat (3) @(negedge clk);
    checkOutput("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    checkResetOutputs("abort");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, target, 8'h00);
    applyStimulus(0, (target + 6) % DEPTH, 8'h00);
    waitDrain();

    // Randomized traffic, including out-of-range addresses and occasional clears
    for (int n = 0; n < 150; n++) begin
      int r;
      int op;
      r  = int'($urandom_range(0, 15));
      op = (r == 0) ? 3 : int'($urandom_range(0, 2));
      applyStimulus(op, int'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end
    waitDrain();
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, i, 8'h00);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
